// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the fir host controller: fir register map, ap_ctrl
// bit positions, controller FSM state encoding and the tap address helper.
// ---------------------------------------------------------------------------
package fir_pkg;

    // fir AXI-Lite register map
    localparam int ADDR_AP_CTRL  = 'h00;
    localparam int ADDR_LEN      = 'h10;
    localparam int ADDR_TAP_BASE = 'h20;

    // ap_ctrl bit indices
    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;
    localparam int AP_IDLE  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_TAP,
        S_WR_START,
        S_STREAM,
        S_POLL_AR,
        S_POLL_R,
        S_FINISH
    } ctrl_state_e;

    // Byte address of tap coefficient i
    function automatic int tap_addr(input int i);
        return ADDR_TAP_BASE + (i << 2);
    endfunction

endpackage

// File: rtl/fir_host_ctrl_axil_wr_beat.sv
// ---------------------------------------------------------------------------
// axil_wr_beat
// One AXI-Lite write beat (AW + W, no B channel). While 'go' is high and no
// beat is in flight, addr/data are latched and awvalid/wvalid rise together.
// Each valid drops on its own handshake; 'complete' pulses for one cycle the
// cycle after both handshakes have finished.
//
// Ports:
//   axis_clk, axis_rst      clock, async active-high reset
//   go                      request a beat (level; re-armed after complete)
//   addr, data              beat address / data, latched at beat start
//   awvalid/awaddr/awready  AXI-Lite write address channel
//   wvalid/wdata/wready     AXI-Lite write data channel
//   complete                single-cycle beat-done pulse
// ---------------------------------------------------------------------------
module axil_wr_beat #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   go,
    input  logic [pADDR_WIDTH-1:0] addr,
    input  logic [pDATA_WIDTH-1:0] data,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   complete
);

    logic active;
    logic aw_ok;
    logic w_ok;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            active   <= 1'b0;
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            awaddr   <= '0;
            wdata    <= '0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            if (!active) begin
                // 'complete' still high means the caller has not yet advanced
                // its addr/data, so hold off one cycle before re-arming.
                if (go && !complete) begin
                    active  <= 1'b1;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= addr;
                    wdata   <= data;
                    aw_ok   <= 1'b0;
                    w_ok    <= 1'b0;
                end
            end else begin
                if (aw_hs) begin
                    awvalid <= 1'b0;
                    aw_ok   <= 1'b1;
                end
                if (w_hs) begin
                    wvalid <= 1'b0;
                    w_ok   <= 1'b1;
                end
                if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                    active   <= 1'b0;
                    complete <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fir_host_ctrl.sv
// ---------------------------------------------------------------------------
// fir_host_ctrl
// Host-side controller for fir. On an accepted cmd_start it writes the data
// length, the tap coefficients and ap_start over AXI-Lite, passes cmd_len
// samples from the upstream source into fir while forwarding fir results
// downstream, then polls ap_ctrl until done/idle or until POLL_MAX reads.
//
// Ports:
//   axis_clk, axis_rst            clock, async active-high reset
//   cmd_start, cmd_len            run request and sample count
//   coef_flat                     tap i at [32i+31:32i]
//   busy, done, err, out_cnt      run status
//   aw*/w*                        AXI-Lite write (no B channel)
//   ar*/r*                        AXI-Lite read (status polling)
//   src_*                         upstream samples in
//   ss_*                          samples to fir
//   sm_*                          results from fir
//   dst_*                         results downstream
// ---------------------------------------------------------------------------
module fir_host_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int POLL_MAX    = 1024
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst,
    input  logic                            cmd_start,
    input  logic [31:0]                     cmd_len,
    input  logic [Tape_Num*pDATA_WIDTH-1:0] coef_flat,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [31:0]                     out_cnt,
    output logic                            awvalid,
    output logic [pADDR_WIDTH-1:0]          awaddr,
    input  logic                            awready,
    output logic                            wvalid,
    output logic [pDATA_WIDTH-1:0]          wdata,
    input  logic                            wready,
    output logic                            arvalid,
    output logic [pADDR_WIDTH-1:0]          araddr,
    input  logic                            arready,
    output logic                            rready,
    input  logic                            rvalid,
    input  logic [pDATA_WIDTH-1:0]          rdata,
    input  logic                            src_tvalid,
    input  logic [pDATA_WIDTH-1:0]          src_tdata,
    output logic                            src_tready,
    output logic                            ss_tvalid,
    output logic [pDATA_WIDTH-1:0]          ss_tdata,
    output logic                            ss_tlast,
    input  logic                            ss_tready,
    input  logic                            sm_tvalid,
    input  logic [pDATA_WIDTH-1:0]          sm_tdata,
    input  logic                            sm_tlast,
    output logic                            sm_tready,
    output logic                            dst_tvalid,
    output logic [pDATA_WIDTH-1:0]          dst_tdata,
    output logic                            dst_tlast,
    input  logic                            dst_tready
);

    localparam int TW = $clog2(Tape_Num + 1);

    ctrl_state_e             state;
    logic [31:0]             len_q;
    logic [31:0]             in_cnt;
    logic [31:0]             poll_cnt;
    logic [TW-1:0]           tap_idx;

    logic                    wb_go;
    logic                    wb_complete;
    logic [pADDR_WIDTH-1:0]  wb_addr;
    logic [pDATA_WIDTH-1:0]  wb_data;

    logic                    in_active;
    logic                    ss_hs;
    logic                    sm_hs;
    logic                    unused_rdata;

    // Only the done/idle status bits matter to the poll loop
    assign unused_rdata = ^{rdata[pDATA_WIDTH-1:AP_IDLE+1], rdata[AP_START]};

    // Address/data for the current write beat follow the FSM state
    always_comb begin
        wb_go   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        case (state)
            S_WR_LEN: begin
                wb_go   = 1'b1;
                wb_addr = pADDR_WIDTH'(ADDR_LEN);
                wb_data = pDATA_WIDTH'(len_q);
            end
            S_WR_TAP: begin
                wb_go   = 1'b1;
                wb_addr = pADDR_WIDTH'(tap_addr(int'(tap_idx)));
                wb_data = coef_flat[int'(tap_idx)*pDATA_WIDTH +: pDATA_WIDTH];
            end
            S_WR_START: begin
                wb_go   = 1'b1;
                wb_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
                wb_data = pDATA_WIDTH'(1 << AP_START);
            end
            default: ;
        endcase
    end

    axil_wr_beat #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_wr_beat (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .go       (wb_go),
        .addr     (wb_addr),
        .data     (wb_data),
        .awvalid  (awvalid),
        .awaddr   (awaddr),
        .awready  (awready),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .wready   (wready),
        .complete (wb_complete)
    );

    // Input path is open only in STREAM and only until len beats have passed
    assign in_active  = (state == S_STREAM) && (in_cnt != len_q);
    assign ss_tvalid  = in_active & src_tvalid;
    assign ss_tdata   = in_active ? src_tdata : '0;
    assign ss_tlast   = in_active && (in_cnt == len_q - 32'd1);
    assign src_tready = in_active & ss_tready;
    assign ss_hs      = ss_tvalid & ss_tready;

    // Result path is open for the whole run
    assign dst_tvalid = busy & sm_tvalid;
    assign dst_tdata  = busy ? sm_tdata : '0;
    assign dst_tlast  = busy & sm_tlast;
    assign sm_tready  = busy & dst_tready;
    assign sm_hs      = sm_tvalid & sm_tready;

    assign araddr = pADDR_WIDTH'(ADDR_AP_CTRL);

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            poll_cnt <= '0;
            tap_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (ss_hs)
                in_cnt <= in_cnt + 32'd1;

            // tlast must appear exactly on result beat len
            if (sm_hs) begin
                out_cnt <= out_cnt + 32'd1;
                if (sm_tlast ^ (out_cnt + 32'd1 == len_q))
                    err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        len_q    <= cmd_len;
                        err      <= 1'b0;
                        out_cnt  <= '0;
                        in_cnt   <= '0;
                        poll_cnt <= '0;
                        tap_idx  <= '0;
                        busy     <= 1'b1;
                        state    <= S_WR_LEN;
                    end
                end
                S_WR_LEN: begin
                    if (wb_complete)
                        state <= S_WR_TAP;
                end
                S_WR_TAP: begin
                    if (wb_complete) begin
                        if (tap_idx == TW'(Tape_Num - 1))
                            state <= S_WR_START;
                        else
                            tap_idx <= tap_idx + 1'b1;
                    end
                end
                S_WR_START: begin
                    if (wb_complete)
                        state <= (len_q == '0) ? S_POLL_AR : S_STREAM;
                end
                S_STREAM: begin
                    if (in_cnt == len_q && out_cnt >= len_q)
                        state <= S_POLL_AR;
                end
                S_POLL_AR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_POLL_R;
                    end else begin
                        arvalid <= 1'b1;
                    end
                end
                S_POLL_R: begin
                    if (rvalid && rready) begin
                        rready   <= 1'b0;
                        poll_cnt <= poll_cnt + 32'd1;
                        // ap_done is a one-cycle flag in fir; ap_idle covers
                        // the case where the pulse fell between reads.
                        if (rdata[AP_DONE] || rdata[AP_IDLE]) begin
                            state <= S_FINISH;
                        end else if (poll_cnt + 32'd1 >= 32'(POLL_MAX)) begin
                            err   <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_POLL_AR;
                        end
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    done  <= ~err;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_host_ctrl.md
Name: fir_host_ctrl

Overview:
- Initiator-side controller for the fir block: the AXI-Lite master and AXI-Stream endpoint pair that drives fir's configuration and stream ports.
- On a command it programs data length and taps, writes ap_start, streams samples from an upstream source into fir, and forwards fir results downstream.
- It then polls ap_done and reports completion or error.
- Sits between the system sequencer/DMA side and fir, replacing the testbench-style host.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, data width for AXI-Lite and AXI-Stream.
- Tape_Num, 11, number of tap coefficients written.
- POLL_MAX, 1024, maximum status reads before timeout.

Ports:
- axis_clk  in  1  single clock.
- axis_rst  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  one-cycle start pulse; ignored unless busy=0.
- cmd_len  in  32  number of samples; latched on accepted cmd_start.
- coef_flat  in  Tape_Num*32  tap i at bits [32i+31:32i]; sampled during tap writes.
- busy  out  1  high from accepted cmd_start until done/err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky until next accepted cmd_start; poll timeout or tlast mismatch.
- out_cnt  out  32  result beats received in the current run.
- awvalid, awaddr, wvalid, wdata  out  1,12,1,32  AXI-Lite write address/data.
- awready, wready  in  1,1.
- arvalid, araddr, rready  out  1,12,1  AXI-Lite read address/ready.
- arready, rvalid  in  1,1; rdata  in  32.
- src_tvalid, src_tdata  in  1,32  upstream samples.
- src_tready  out  1.
- ss_tvalid, ss_tdata, ss_tlast  out  1,32,1  stream into fir.
- ss_tready  in  1.
- sm_tvalid, sm_tdata, sm_tlast  in  1,32,1  stream from fir.
- sm_tready  out  1.
- dst_tvalid, dst_tdata, dst_tlast  out  1,32,1  results downstream.
- dst_tready  in  1.

Behaviour:
- Reset (async, axis_rst=1):
  - State IDLE.
  - All valid/ready outputs, busy, done, err: 0.
  - out_cnt, addresses, wdata: 0.
- FSM states: IDLE, WR_LEN, WR_TAP, WR_START, STREAM, POLL_AR, POLL_R, FINISH.
- IDLE: accepted cmd_start latches cmd_len, clears err and out_cnt, sets busy, and moves to WR_LEN.
- AXI-Lite write beat:
  - Assert awvalid and wvalid in the same cycle.
  - Each is held with stable addr/data until its own ready is sampled high; the two handshakes may complete in different cycles.
  - The beat completes the cycle after both have completed.
  - There is no B channel.
- Write sequence:
  - WR_LEN: addr 0x10, data cmd_len.
  - WR_TAP: addr 0x20+4i, data tap i, for i=0..Tape_Num-1, one beat each, in ascending order.
  - WR_START: addr 0x00, data 0x1.
  - Then enter STREAM.
- STREAM:
  - ss_tvalid=src_tvalid, ss_tdata=src_tdata, src_tready=ss_tready (combinational pass-through, gated by state).
  - Input counter increments on each ss handshake; ss_tlast=1 when the counter equals len-1.
  - Gating stops after len beats; src_tready=0 afterwards.
  - dst_* = sm_* and sm_tready=dst_tready during busy.
  - out_cnt increments on each sm handshake.
  - If sm_tlast is seen on a beat other than beat len, or beat len arrives without sm_tlast, set err.
  - Leave STREAM when len inputs are sent and len outputs are received.
- POLL_AR/POLL_R:
  - Assert arvalid with araddr=0x00 until arready.
  - Then rready=1 until rvalid; capture rdata.
  - If rdata[1]=1 (ap_done), go to FINISH.
  - Otherwise re-poll; after POLL_MAX reads without ap_done, set err and go to FINISH.
  - ap_done is one cycle wide in fir, so the read of bit 2 (ap_idle)=1 is also accepted as completion.
- FINISH: busy=0; done=1 for one cycle only if err=0; return to IDLE.
- cmd_len=0: skip STREAM (no beats, no tlast), go straight from WR_START to POLL_AR.
- cmd_start while busy: ignored, no state change.
- Reset mid-run: all handshakes drop immediately; no partial beat completes afterwards.
- Widths: counters are 32-bit unsigned; addresses are pADDR_WIDTH; tap address = 0x20 + (i<<2).

Decomposition:
- Shared package fir_pkg:
  - Register address constants: ADDR_AP_CTRL=0x00, ADDR_LEN=0x10, ADDR_TAP_BASE=0x20.
  - ap_ctrl bit indices: START=0, DONE=1, IDLE=2.
  - FSM state enum.
- One natural sub-module: axil_wr_beat, which implements the independent aw/w handshake and a single-cycle complete pulse; instantiated once and reused for all writes.

Test Plan:
- Writes with awready/wready at 1: cmd_len=64, taps 0..10 → AXI writes in order: 0x10←64, then 0x20..0x48 ←taps, then 0x00←1; exactly 13 beats.
- Skewed handshakes: wready two cycles before awready on every beat → awaddr/wdata held stable throughout; no beat duplicated or dropped.
- Stream length 5, responder returns 5 beats with tlast on the 5th, rdata=0x2 on the 3rd poll → ss_tlast only on the 5th input; out_cnt=5; done pulse; err=0.
- Responder asserts sm_tlast on beat 3 of 5 → err=1; no done pulse; busy falls after the poll.
- Responder never reports done, POLL_MAX=8 → exactly 8 reads, then err=1; busy=0.
- Assert axis_rst in STREAM after 2 beats → all outputs 0 immediately; a new cmd_start after release restarts from WR_LEN.
